pc_gen: RTL and testbench

Parametrised program-counter generator for the IF stage. It owns the fetch PC register and drives a req/gnt handshake to instruction memory. It arbitrates redirects from ID (JAL/JALR), EX (taken branch) and, optionally, the trap unit. Redirects that arrive while a fetch request is waiting for its grant are buffered, so the fetch address never changes under an ungranted request.

---
 rtl/core_pkg.sv | 24 ++
 rtl/pc_redirect_arb.sv | 47 ++++
 rtl/pc_gen.sv | 106 ++++++++++
 tb/tb_pc_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: PC generator FSM states, redirect sources and PC source select.
package core_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } pc_gen_state_t;

    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_JUMP   = 2'd1,
        RD_BRANCH = 2'd2,
        RD_TRAP   = 2'd3
    } redirect_src_t;

    typedef enum logic [1:0] {
        PC_BOOT   = 2'd0,
        PC_INCR   = 2'd1,
        PC_JUMP   = 2'd2,
        PC_BRANCH = 2'd3
    } pc_source_t;

endpackage

// File: rtl/pc_redirect_arb.sv
// Same-cycle redirect priority select (trap > branch > jump) with target alignment.
// Trap source present only when PC_GEN_TRAP_EN is defined.
module pc_redirect_arb
    import core_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int PC_STEP = 4
) (
`ifdef PC_GEN_TRAP_EN
    input  logic             trap_valid_i,
    input  logic [WIDTH-1:0] trap_target_i,
`endif
    input  logic             branch_taken_ex_i,
    input  logic [WIDTH-1:0] branch_target_ex_i,
    input  logic             jump_valid_id_i,
    input  logic [WIDTH-1:0] jump_target_id_i,
    output redirect_src_t    src_o,
    output logic [WIDTH-1:0] target_o,
    output logic             misaligned_o
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = (PC_STEP == 4) ? ~WIDTH'(3) : ~WIDTH'(1);

    logic [WIDTH-1:0] raw_target;

    always_comb begin
        src_o      = RD_NONE;
        raw_target = '0;
`ifdef PC_GEN_TRAP_EN
        if (trap_valid_i) begin
            src_o      = RD_TRAP;
            raw_target = trap_target_i;
        end else
`endif
        if (branch_taken_ex_i) begin
            src_o      = RD_BRANCH;
            raw_target = branch_target_ex_i;
        end else if (jump_valid_id_i) begin
            src_o      = RD_JUMP;
            raw_target = jump_target_id_i;
        end
    end

    assign target_o     = raw_target & ALIGN_MASK;
    assign misaligned_o = (src_o != RD_NONE) && (PC_STEP == 4) && raw_target[1];

endmodule

// File: rtl/pc_gen.sv
// IF-stage program counter generator with req/gnt fetch handshake and buffered redirects.
// Optional trap redirect source enabled by defining PC_GEN_TRAP_EN.
module pc_gen
    import core_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] BOOT_ADDR = '0,
    parameter int               PC_STEP   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             fetch_req_o,
    output logic [WIDTH-1:0] fetch_addr_o,
    input  logic             fetch_gnt_i,
    input  logic             stall_if_i,
    input  logic             jump_valid_id_i,
    input  logic [WIDTH-1:0] jump_target_id_i,
    input  logic             branch_taken_ex_i,
    input  logic [WIDTH-1:0] branch_target_ex_i,
`ifdef PC_GEN_TRAP_EN
    input  logic             trap_valid_i,
    input  logic [WIDTH-1:0] trap_target_i,
`endif
    output logic             flush_if_o,
    output logic             flush_id_o,
    output logic             misaligned_o
);

    pc_gen_state_t    state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_addr_q, pend_addr_d;

    redirect_src_t    rd_src;
    logic [WIDTH-1:0] rd_target;
    logic             rd_misaligned;
    logic             rd_valid;

    pc_redirect_arb #(.WIDTH(WIDTH), .PC_STEP(PC_STEP)) u_arb (
`ifdef PC_GEN_TRAP_EN
        .trap_valid_i      (trap_valid_i),
        .trap_target_i     (trap_target_i),
`endif
        .branch_taken_ex_i (branch_taken_ex_i),
        .branch_target_ex_i(branch_target_ex_i),
        .jump_valid_id_i   (jump_valid_id_i),
        .jump_target_id_i  (jump_target_id_i),
        .src_o             (rd_src),
        .target_o          (rd_target),
        .misaligned_o      (rd_misaligned)
    );

    // Sideband outputs are forced quiet while reset is held, whatever the inputs do.
    assign rd_valid     = (rd_src != RD_NONE) && !rst_i;
    assign fetch_req_o  = (state_q == PEND) || ((state_q == RUN) && !stall_if_i);
    assign fetch_addr_o = pc_q;
    assign flush_if_o   = rd_valid || (state_q == PEND);
    assign flush_id_o   = !rst_i && ((rd_src == RD_BRANCH) || (rd_src == RD_TRAP));
    assign misaligned_o = rd_misaligned && !rst_i;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_addr_d = pend_addr_q;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
                if (rd_valid) pc_d = rd_target;
            end
            RUN: begin
                if (rd_valid) begin
                    // An ungranted request must keep its address; park the target.
                    if (fetch_req_o && !fetch_gnt_i) begin
                        pend_addr_d = rd_target;
                        state_d     = PEND;
                    end else begin
                        pc_d = rd_target;
                    end
                end else if (fetch_req_o && fetch_gnt_i) begin
                    pc_d = pc_q + WIDTH'(PC_STEP);
                end
            end
            PEND: begin
                if (fetch_gnt_i) begin
                    pc_d    = rd_valid ? rd_target : pend_addr_q;
                    state_d = RUN;
                end else if (rd_valid) begin
                    pend_addr_d = rd_target;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= BOOT;
            pc_q        <= BOOT_ADDR;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; a 16-bit instance covers PC wrap.
// Trap scenario runs only when PC_GEN_TRAP_EN is defined.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        stall_if;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
`ifdef PC_GEN_TRAP_EN
    logic        trap_valid;
    logic [31:0] trap_target;
`endif
    logic        flush_if;
    logic        flush_id;
    logic        misaligned;

    logic        rst16;
    logic        req16;
    logic [15:0] addr16;
    logic        gnt16;
    logic        stall16;
    logic        jump16;
    logic [15:0] jt16;
    logic        branch16;
    logic [15:0] bt16;
`ifdef PC_GEN_TRAP_EN
    logic        trap16;
    logic [15:0] tt16;
`endif
    logic        flush_if16;
    logic        flush_id16;
    logic        mis16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_gen #(.WIDTH(32), .BOOT_ADDR(32'h8000_0000), .PC_STEP(4)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .fetch_req_o       (fetch_req),
        .fetch_addr_o      (fetch_addr),
        .fetch_gnt_i       (fetch_gnt),
        .stall_if_i        (stall_if),
        .jump_valid_id_i   (jump_valid),
        .jump_target_id_i  (jump_target),
        .branch_taken_ex_i (branch_taken),
        .branch_target_ex_i(branch_target),
`ifdef PC_GEN_TRAP_EN
        .trap_valid_i      (trap_valid),
        .trap_target_i     (trap_target),
`endif
        .flush_if_o        (flush_if),
        .flush_id_o        (flush_id),
        .misaligned_o      (misaligned)
    );

    pc_gen #(.WIDTH(16), .BOOT_ADDR(16'hFFF8), .PC_STEP(4)) dut16 (
        .clk_i             (clk),
        .rst_i             (rst16),
        .fetch_req_o       (req16),
        .fetch_addr_o      (addr16),
        .fetch_gnt_i       (gnt16),
        .stall_if_i        (stall16),
        .jump_valid_id_i   (jump16),
        .jump_target_id_i  (jt16),
        .branch_taken_ex_i (branch16),
        .branch_target_ex_i(bt16),
`ifdef PC_GEN_TRAP_EN
        .trap_valid_i      (trap16),
        .trap_target_i     (tt16),
`endif
        .flush_if_o        (flush_if16),
        .flush_id_o        (flush_id16),
        .misaligned_o      (mis16)
    );

    task automatic test_reset;
        rst = 1'b1; fetch_gnt = 1'b1; stall_if = 1'b0;
        jump_valid = 1'b0; jump_target = '0; branch_taken = 1'b0; branch_target = '0;
`ifdef PC_GEN_TRAP_EN
        trap_valid = 1'b0; trap_target = '0;
`endif
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b exp 0", fetch_req); end
        n_cmp++; if (fetch_addr !== 32'h8000_0000) begin n_err++; $display("FAIL rst_addr got %h exp 80000000", fetch_addr); end
        n_cmp++; if ({flush_if, flush_id, misaligned} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b exp 000", {flush_if, flush_id, misaligned}); end
        rst = 1'b0;
        #1;
        n_cmp++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL boot_req got %b exp 0", fetch_req); end
        @(negedge clk); #1;
        n_cmp++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h8000_0000) begin n_err++; $display("FAIL first_fetch got %b/%h exp 1/80000000", fetch_req, fetch_addr); end
        @(negedge clk); #1;
        n_cmp++; if (fetch_addr !== 32'h8000_0004) begin n_err++; $display("FAIL seq1 got %h exp 80000004", fetch_addr); end
        @(negedge clk); #1;
        n_cmp++; if (fetch_addr !== 32'h8000_0008) begin n_err++; $display("FAIL seq2 got %h exp 80000008", fetch_addr); end
    endtask

    task automatic test_branch_vs_jump;
        @(negedge clk);
        branch_taken = 1'b1; branch_target = 32'h100;
        jump_valid = 1'b1; jump_target = 32'h200;
        #1;
        n_cmp++; if ({flush_if, flush_id} !== 2'b11) begin n_err++; $display("FAIL br_flush got %b exp 11", {flush_if, flush_id}); end
        @(negedge clk);
        branch_taken = 1'b0; jump_valid = 1'b0;
        #1;
        n_cmp++; if (fetch_addr !== 32'h100) begin n_err++; $display("FAIL br_addr got %h exp 00000100", fetch_addr); end
        n_cmp++; if ({flush_if, flush_id} !== 2'b00) begin n_err++; $display("FAIL br_flush_clr got %b exp 00", {flush_if, flush_id}); end
    endtask

    task automatic test_pend_jump;
        @(negedge clk);
        fetch_gnt = 1'b0; jump_valid = 1'b1; jump_target = 32'h40;
        #1;
        n_cmp++; if (fetch_addr !== 32'h104 || {flush_if, flush_id} !== 2'b10) begin n_err++; $display("FAIL pj_redir got %h/%b exp 00000104/10", fetch_addr, {flush_if, flush_id}); end
        @(negedge clk);
        jump_valid = 1'b0;
        #1;
        n_cmp++; if (fetch_addr !== 32'h104 || fetch_req !== 1'b1 || flush_if !== 1'b1) begin n_err++; $display("FAIL pj_pend1 got %h/%b/%b exp 00000104/1/1", fetch_addr, fetch_req, flush_if); end
        @(negedge clk); #1;
        n_cmp++; if (fetch_addr !== 32'h104 || fetch_req !== 1'b1 || flush_if !== 1'b1) begin n_err++; $display("FAIL pj_pend2 got %h/%b/%b exp 00000104/1/1", fetch_addr, fetch_req, flush_if); end
        @(negedge clk);
        fetch_gnt = 1'b1;
        #1;
        n_cmp++; if (fetch_addr !== 32'h104 || flush_if !== 1'b1) begin n_err++; $display("FAIL pj_gnt got %h/%b exp 00000104/1", fetch_addr, flush_if); end
        @(negedge clk); #1;
        n_cmp++; if (fetch_addr !== 32'h40 || flush_if !== 1'b0) begin n_err++; $display("FAIL pj_target got %h/%b exp 00000040/0", fetch_addr, flush_if); end
    endtask

    task automatic test_pend_overwrite;
        @(negedge clk);
        fetch_gnt = 1'b0; branch_taken = 1'b1; branch_target = 32'h300;
        #1;
        n_cmp++; if (fetch_addr !== 32'h44 || flush_id !== 1'b1) begin n_err++; $display("FAIL po_branch got %h/%b exp 00000044/1", fetch_addr, flush_id); end
        @(negedge clk);
        branch_taken = 1'b0; jump_valid = 1'b1; jump_target = 32'h500;
        #1;
        n_cmp++; if (fetch_addr !== 32'h44 || {flush_if, flush_id} !== 2'b10) begin n_err++; $display("FAIL po_jump got %h/%b exp 00000044/10", fetch_addr, {flush_if, flush_id}); end
        @(negedge clk);
        jump_valid = 1'b0; fetch_gnt = 1'b1;
        #1;
        n_cmp++; if (fetch_addr !== 32'h44) begin n_err++; $display("FAIL po_gnt got %h exp 00000044", fetch_addr); end
        @(negedge clk); #1;
        n_cmp++; if (fetch_addr !== 32'h500) begin n_err++; $display("FAIL po_target got %h exp 00000500", fetch_addr); end
    endtask

    task automatic test_misaligned;
        @(negedge clk);
        jump_valid = 1'b1; jump_target = 32'h42;
        #1;
        n_cmp++; if (misaligned !== 1'b1) begin n_err++; $display("FAIL mis_pulse got %b exp 1", misaligned); end
        @(negedge clk);
        jump_valid = 1'b0;
        #1;
        n_cmp++; if (fetch_addr !== 32'h40 || misaligned !== 1'b0) begin n_err++; $display("FAIL mis_addr got %h/%b exp 00000040/0", fetch_addr, misaligned); end
    endtask

    task automatic test_stall;
        @(negedge clk);
        stall_if = 1'b1;
        #1;
        n_cmp++; if (fetch_req !== 1'b0 || fetch_addr !== 32'h44) begin n_err++; $display("FAIL st_req got %b/%h exp 0/00000044", fetch_req, fetch_addr); end
        @(negedge clk);
        jump_valid = 1'b1; jump_target = 32'h80;
        #1;
        n_cmp++; if (fetch_addr !== 32'h44 || flush_if !== 1'b1) begin n_err++; $display("FAIL st_hold got %h/%b exp 00000044/1", fetch_addr, flush_if); end
        @(negedge clk);
        jump_valid = 1'b0;
        #1;
        n_cmp++; if (fetch_addr !== 32'h80 || fetch_req !== 1'b0) begin n_err++; $display("FAIL st_redir got %h/%b exp 00000080/0", fetch_addr, fetch_req); end
        stall_if = 1'b0;
        #1;
        n_cmp++; if (fetch_req !== 1'b1) begin n_err++; $display("FAIL st_release got %b exp 1", fetch_req); end
    endtask

`ifdef PC_GEN_TRAP_EN
    task automatic test_trap;
        @(negedge clk);
        trap_valid = 1'b1; trap_target = 32'h1C0;
        branch_taken = 1'b1; branch_target = 32'h100;
        jump_valid = 1'b1; jump_target = 32'h200;
        #1;
        n_cmp++; if ({flush_if, flush_id} !== 2'b11) begin n_err++; $display("FAIL trap_flush got %b exp 11", {flush_if, flush_id}); end
        @(negedge clk);
        trap_valid = 1'b0; branch_taken = 1'b0; jump_valid = 1'b0;
        #1;
        n_cmp++; if (fetch_addr !== 32'h1C0) begin n_err++; $display("FAIL trap_addr got %h exp 000001c0", fetch_addr); end
    endtask
`endif

    task automatic test_reset_in_pend;
        @(negedge clk);
        fetch_gnt = 1'b0; jump_valid = 1'b1; jump_target = 32'h600;
        @(negedge clk);
        jump_valid = 1'b0;
        #1;
        n_cmp++; if (flush_if !== 1'b1 || fetch_req !== 1'b1) begin n_err++; $display("FAIL rp_pend got %b/%b exp 1/1", flush_if, fetch_req); end
        rst = 1'b1;
        #1;
        n_cmp++; if (fetch_addr !== 32'h8000_0000 || fetch_req !== 1'b0 || flush_if !== 1'b0) begin n_err++; $display("FAIL rp_reset got %h/%b/%b exp 80000000/0/0", fetch_addr, fetch_req, flush_if); end
        @(negedge clk);
        rst = 1'b0; fetch_gnt = 1'b1;
        #1;
        n_cmp++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL rp_boot got %b exp 0", fetch_req); end
        @(negedge clk); #1;
        n_cmp++; if (fetch_addr !== 32'h8000_0000 || fetch_req !== 1'b1) begin n_err++; $display("FAIL rp_first got %h/%b exp 80000000/1", fetch_addr, fetch_req); end
        @(negedge clk); #1;
        n_cmp++; if (fetch_addr !== 32'h8000_0004) begin n_err++; $display("FAIL rp_seq got %h exp 80000004", fetch_addr); end
    endtask

    task automatic test_wrap16;
        @(negedge clk);
        rst16 = 1'b0;
        #1;
        n_cmp++; if (req16 !== 1'b0) begin n_err++; $display("FAIL w16_boot got %b exp 0", req16); end
        @(negedge clk); #1;
        n_cmp++; if (addr16 !== 16'hFFF8 || req16 !== 1'b1) begin n_err++; $display("FAIL w16_first got %h/%b exp fff8/1", addr16, req16); end
        @(negedge clk); #1;
        n_cmp++; if (addr16 !== 16'hFFFC) begin n_err++; $display("FAIL w16_top got %h exp fffc", addr16); end
        @(negedge clk); #1;
        n_cmp++; if (addr16 !== 16'h0000) begin n_err++; $display("FAIL w16_wrap got %h exp 0000", addr16); end
        jump16 = 1'b1; jt16 = 16'h0042;
        #1;
        n_cmp++; if (mis16 !== 1'b1 || flush_if16 !== 1'b1) begin n_err++; $display("FAIL w16_mis got %b/%b exp 1/1", mis16, flush_if16); end
        @(negedge clk);
        jump16 = 1'b0;
        #1;
        n_cmp++; if (addr16 !== 16'h0040 || mis16 !== 1'b0) begin n_err++; $display("FAIL w16_target got %h/%b exp 0040/0", addr16, mis16); end
    endtask

    initial begin
        rst16 = 1'b1; gnt16 = 1'b1; stall16 = 1'b0;
        jump16 = 1'b0; jt16 = '0; branch16 = 1'b0; bt16 = '0;
`ifdef PC_GEN_TRAP_EN
        trap16 = 1'b0; tt16 = '0;
`endif
        test_reset();
        test_branch_vs_jump();
        test_pend_jump();
        test_pend_overwrite();
        test_misaligned();
        test_stall();
`ifdef PC_GEN_TRAP_EN
        test_trap();
`endif
        test_reset_in_pend();
        test_wrap16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
